// File: rtl/sd_init_pkg.sv
// Shared types and constants for the SD SPI-mode power-up sequencer.
// Holds FSM/step enums, command indices, CRC7 values and error codes.
package sd_init_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [2:0] {
    S_CMD0,
    S_CMD8,
    S_CMD55,
    S_ACMD41,
    S_CMD58
  } step_t;

  localparam logic [5:0] CMD0_IDX   = 6'd0;
  localparam logic [5:0] CMD8_IDX   = 6'd8;
  localparam logic [5:0] CMD55_IDX  = 6'd55;
  localparam logic [5:0] ACMD41_IDX = 6'd41;
  localparam logic [5:0] CMD58_IDX  = 6'd58;

  localparam logic [6:0] CRC_CMD0      = 7'h4A;
  localparam logic [6:0] CRC_CMD8      = 7'h43;
  localparam logic [6:0] CRC_CMD55     = 7'h32;
  localparam logic [6:0] CRC_ACMD41_HC = 7'h3B;
  localparam logic [6:0] CRC_ACMD41_SC = 7'h72;
  localparam logic [6:0] CRC_CMD58     = 7'h7E;

  localparam logic [31:0] ARG_CMD8  = 32'h0000_01AA;
  localparam logic [31:0] ARG_HCS   = 32'h4000_0000;

  localparam logic [7:0] R1_READY   = 8'h00;
  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h05;

  localparam int RESP_BYTES = 5;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CMD0    = 3'd1;
  localparam logic [2:0] ERR_CMD8    = 3'd2;
  localparam logic [2:0] ERR_CMD55   = 3'd3;
  localparam logic [2:0] ERR_ACMD41  = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_CMD58   = 3'd6;
  localparam logic [2:0] ERR_WDOG    = 3'd7;

  typedef struct packed {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        long_resp;
  } cmd_fields_t;

  function automatic cmd_fields_t step_fields(
    input step_t s,
    input logic  hcs
  );
    cmd_fields_t f;
    f = '0;
    unique case (s)
      S_CMD0: begin
        f.cmd = CMD0_IDX;
        f.crc = CRC_CMD0;
      end
      S_CMD8: begin
        f.cmd = CMD8_IDX;
        f.arg = ARG_CMD8;
        f.crc = CRC_CMD8;
        f.long_resp = 1'b1;
      end
      S_CMD55: begin
        f.cmd = CMD55_IDX;
        f.crc = CRC_CMD55;
      end
      S_ACMD41: begin
        f.cmd = ACMD41_IDX;
        f.arg = hcs ? ARG_HCS : 32'h0;
        f.crc = hcs ? CRC_ACMD41_HC
                    : CRC_ACMD41_SC;
      end
      S_CMD58: begin
        f.cmd = CMD58_IDX;
        f.crc = CRC_CMD58;
        f.long_resp = 1'b1;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sd_resp_capture.sv
// Five-byte response snoop buffer: cleared to FF, captures in-range writes.
// Ports: clk, rst, clr, en, wr, addr, data -> bytes[4:0] (byte 0 is R1).
module sd_resp_capture
  import sd_init_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           wr,
  input  logic [AW-1:0]  addr,
  input  logic [7:0]     data,
  output logic [4:0][7:0] bytes
);

  logic [4:0][7:0] bytes_q;
  logic [4:0][7:0] bytes_d;

  always_comb begin
    bytes_d = bytes_q;
    if (clr) begin
      bytes_d = {RESP_BYTES{8'hFF}};
    end else if (en && wr &&
                 addr < AW'(RESP_BYTES)) begin
      bytes_d[addr[2:0]] = data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_q <= {RESP_BYTES{8'hFF}};
    end else begin
      bytes_q <= bytes_d;
    end
  end

  assign bytes = bytes_q;

endmodule

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD power-up sequencer driving sd_controller (CMD0/8/55/41/58).
// Ports: init_* host handshake, sd_* command bus, resp_* snoop of R1/R3/R7.
// Optional SD_INIT_WATCHDOG_EN adds a per-command sd_done timeout (code 7).
module sd_init_sequencer
  import sd_init_pkg::*;
#(
  parameter int MEMORY_SIZE_IN_BYTES = 10,
  parameter int ACMD41_MAX_TRIES = 1000,
  parameter int WATCHDOG_CYCLES = 100000,
  localparam int AW = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_start,
  output logic          init_busy,
  output logic          init_done,
  output logic          init_error,
  output logic [2:0]    err_code,
  output logic          sdhc,
  output logic [5:0]    sd_cmd,
  output logic [31:0]   sd_arg,
  output logic [6:0]    sd_crc,
  output logic [AW-1:0] sd_nresponse,
  output logic          sd_start,
  input  logic          sd_done,
  input  logic          resp_wr,
  input  logic [AW-1:0] resp_addr,
  input  logic [7:0]    resp_data
);

  state_t state_q, state_d;
  step_t  step_q, step_d;

  logic [15:0]   tries_q, tries_d;
  logic          hcs_q, hcs_d;
  logic          sdhc_q, sdhc_d;
  logic [2:0]    err_q, err_d;
  logic [5:0]    cmd_q, cmd_d;
  logic [31:0]   arg_q, arg_d;
  logic [6:0]    crc_q, crc_d;
  logic [AW-1:0] nresp_q, nresp_d;

  logic [4:0][7:0] rbuf;
  cmd_fields_t     f;

`ifdef SD_INIT_WATCHDOG_EN
  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
`endif

  sd_resp_capture #(
    .AW(AW)
  ) u_cap (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ISSUE),
    .en   (state_q == WAIT),
    .wr   (resp_wr),
    .addr (resp_addr),
    .data (resp_data),
    .bytes(rbuf)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tries_d = tries_q;
    hcs_d   = hcs_q;
    sdhc_d  = sdhc_q;
    err_d   = err_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    crc_d   = crc_q;
    nresp_d = nresp_q;
`ifdef SD_INIT_WATCHDOG_EN
    wd_d    = wd_q;
`endif

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (init_start) begin
          sdhc_d  = 1'b0;
          hcs_d   = 1'b0;
          err_d   = ERR_NONE;
          tries_d = '0;
          step_d  = S_CMD0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef SD_INIT_WATCHDOG_EN
        wd_d = '0;
`endif
      end
      WAIT: begin
        if (sd_done) begin
          state_d = CHECK;
        end
`ifdef SD_INIT_WATCHDOG_EN
        else if (wd_q ==
                 WDW'(WATCHDOG_CYCLES - 1)) begin
          err_d   = ERR_WDOG;
          state_d = ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      CHECK: begin
        state_d = ISSUE;
        unique case (step_q)
          S_CMD0: begin
            if (rbuf[0] == R1_IDLE) begin
              step_d = S_CMD8;
            end else begin
              err_d   = ERR_CMD0;
              state_d = ERROR;
            end
          end
          S_CMD8: begin
            // R7 echo of voltage/check pattern marks a v2 card
            if (rbuf[0] == R1_IDLE &&
                rbuf[3][3:0] == 4'h1 &&
                rbuf[4] == 8'hAA) begin
              hcs_d  = 1'b1;
              step_d = S_CMD55;
            end else if (rbuf[0] ==
                         R1_ILLEGAL) begin
              hcs_d  = 1'b0;
              step_d = S_CMD55;
            end else begin
              err_d   = ERR_CMD8;
              state_d = ERROR;
            end
          end
          S_CMD55: begin
            if (rbuf[0] == R1_READY ||
                rbuf[0] == R1_IDLE) begin
              step_d = S_ACMD41;
            end else begin
              err_d   = ERR_CMD55;
              state_d = ERROR;
            end
          end
          S_ACMD41: begin
            unique case (1'b1)
              rbuf[0] == R1_READY: begin
                if (hcs_q) begin
                  step_d = S_CMD58;
                end else begin
                  sdhc_d  = 1'b0;
                  state_d = DONE;
                end
              end
              rbuf[0] == R1_IDLE: begin
                tries_d = tries_q + 16'd1;
                if (tries_d ==
                    16'(ACMD41_MAX_TRIES)) begin
                  err_d   = ERR_TIMEOUT;
                  state_d = ERROR;
                end else begin
                  step_d = S_CMD55;
                end
              end
              default: begin
                err_d   = ERR_ACMD41;
                state_d = ERROR;
              end
            endcase
          end
          S_CMD58: begin
            if (rbuf[0] == R1_READY) begin
              sdhc_d  = rbuf[1][6];
              state_d = DONE;
            end else begin
              err_d   = ERR_CMD58;
              state_d = ERROR;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Fields load on entry so they are valid with the sd_start pulse
    f = step_fields(step_d, hcs_d);
    if (state_d == ISSUE) begin
      cmd_d   = f.cmd;
      arg_d   = f.arg;
      crc_d   = f.crc;
      nresp_d = f.long_resp ? AW'(5) : AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= S_CMD0;
      tries_q <= '0;
      hcs_q   <= 1'b0;
      sdhc_q  <= 1'b0;
      err_q   <= ERR_NONE;
      cmd_q   <= '0;
      arg_q   <= '0;
      crc_q   <= '0;
      nresp_q <= '0;
`ifdef SD_INIT_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tries_q <= tries_d;
      hcs_q   <= hcs_d;
      sdhc_q  <= sdhc_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      crc_q   <= crc_d;
      nresp_q <= nresp_d;
`ifdef SD_INIT_WATCHDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign init_busy = (state_q == ISSUE) ||
                     (state_q == WAIT)  ||
                     (state_q == CHECK);
  assign init_done    = (state_q == DONE);
  assign init_error   = (state_q == ERROR);
  assign err_code     = err_q;
  assign sdhc         = sdhc_q;
  assign sd_cmd       = cmd_q;
  assign sd_arg       = arg_q;
  assign sd_crc       = crc_q;
  assign sd_nresponse = nresp_q;
  assign sd_start     = (state_q == ISSUE);

endmodule
